// File: rtl/aes_inv_data_path.sv
// -----------------------------------------------------------------------------
// aes_inv_data_path
//   Iterative AES-128 inverse cipher, one round per clock. The cipher key is
//   expanded forward into an 11-entry round-key store. The round keys are then
//   applied in reverse order, rk10 down to rk0. The expanded key is cached, so
//   later blocks under the same key go straight to the rounds.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : synchronous reset, ACTIVE-HIGH (1 = reset)
//   i_start        : start request, honoured only while idle
//   i_new_key      : 1 = expand i_key for this block, 0 = reuse cached keys
//   i_cypher_text  : ciphertext, byte 0 in [127:120], captured on accept
//   i_key          : cipher key, captured on accept when expanding
//   o_plain_text   : registered plaintext, held until the next completion
//   o_valid        : one-cycle pulse when o_plain_text has just been updated
//   o_busy         : high in every state except idle
//   o_key_valid    : a full key expansion has completed since reset
// -----------------------------------------------------------------------------
module aes_inv_data_path #(
    parameter int RND_SIZE = 128,
    parameter int WRD_SIZE = 32,
    parameter int NUM_BLK  = 4,
    parameter int NUM_RND  = 10,
    parameter int CNT_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_new_key,
    input  logic [RND_SIZE-1:0] i_cypher_text,
    input  logic [RND_SIZE-1:0] i_key,
    output logic [RND_SIZE-1:0] o_plain_text,
    output logic                o_valid,
    output logic                o_busy,
    output logic                o_key_valid
);

    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL} state_t;

    // GF(2^8) multiply, reduction polynomial 0x11b
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0 naturally)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    // Forward S-box: inverse followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
                 ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine map followed by the field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    // Row r of the output takes column (c - r) mod 4 of the input
    function automatic logic [RND_SIZE-1:0] inv_shift_rows(input logic [RND_SIZE-1:0] s);
        logic [RND_SIZE-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[RND_SIZE-1-8*(4*c+r) -: 8] = s[RND_SIZE-1-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [WRD_SIZE-1:0] inv_mix_col(input logic [WRD_SIZE-1:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09),
                gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d),
                gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b),
                gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e)};
    endfunction

    function automatic logic [7:0] rcon(input logic [CNT_SIZE-1:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t                state_reg, state_next;
    logic [CNT_SIZE-1:0]   cnt_reg;
    logic [RND_SIZE-1:0]   ct_reg, st_reg, st_next, pt_reg;
    logic                  valid_reg, kv_reg;
    logic [RND_SIZE-1:0]   rk_mem [0:NUM_RND];

    logic [RND_SIZE-1:0]   round_key, prev_key, next_key;
    logic [RND_SIZE-1:0]   shifted, sub_bytes, add_key, mixed;
    logic [WRD_SIZE-1:0]   rot_word, sub_word, rcon_word, key_acc;
    logic                  accept, expand;
    logic                  rk_we;
    logic [CNT_SIZE-1:0]   rk_waddr;
    logic [RND_SIZE-1:0]   rk_wdata;

    assign accept = (state_reg == S_IDLE) && i_start;
    // A reuse request without a cached key silently falls back to expansion
    assign expand = accept && (i_new_key || !kv_reg);

    // cnt selects the round key; it reaches 0 in FINAL, picking rk[0]
    assign round_key = rk_mem[cnt_reg];
    assign prev_key  = rk_mem[cnt_reg - 1'b1];

    // ---------------- key schedule ----------------
    assign rot_word  = {prev_key[WRD_SIZE-9:0], prev_key[WRD_SIZE-1 -: 8]};
    assign rcon_word = {rcon(cnt_reg), {(WRD_SIZE-8){1'b0}}};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub_word
            assign sub_word[WRD_SIZE-1-8*gi -: 8] = sbox(rot_word[WRD_SIZE-1-8*gi -: 8]);
        end
    endgenerate

    // Word k of the new key is temp ^ w0 ^ ... ^ wk of the previous key
    always_comb begin
        next_key = '0;
        key_acc  = sub_word ^ rcon_word;
        for (int k = 0; k < NUM_BLK; k++) begin
            key_acc = key_acc ^ prev_key[RND_SIZE-1-WRD_SIZE*k -: WRD_SIZE];
            next_key[RND_SIZE-1-WRD_SIZE*k -: WRD_SIZE] = key_acc;
        end
    end

    // Single write port into the round-key store
    always_comb begin
        rk_we    = 1'b0;
        rk_waddr = cnt_reg;
        rk_wdata = next_key;
        if (expand) begin
            rk_we    = 1'b1;
            rk_waddr = '0;
            rk_wdata = i_key;
        end else if (state_reg == S_KEYEXP) begin
            rk_we    = 1'b1;
        end
    end

    // ---------------- round datapath ----------------
    assign shifted = inv_shift_rows(st_reg);
    assign add_key = sub_bytes ^ round_key;

    generate
        for (gi = 0; gi < 4*NUM_BLK; gi++) begin : g_inv_sub
            assign sub_bytes[RND_SIZE-1-8*gi -: 8] = inv_sbox(shifted[RND_SIZE-1-8*gi -: 8]);
        end
        for (gi = 0; gi < NUM_BLK; gi++) begin : g_inv_mix
            assign mixed[RND_SIZE-1-WRD_SIZE*gi -: WRD_SIZE] =
                inv_mix_col(add_key[RND_SIZE-1-WRD_SIZE*gi -: WRD_SIZE]);
        end
    endgenerate

    always_comb begin
        st_next = st_reg;
        case (state_reg)
            S_INIT:  st_next = ct_reg ^ rk_mem[NUM_RND];
            S_ROUND: st_next = mixed;
            default: st_next = st_reg;
        endcase
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = expand ? S_KEYEXP : S_INIT;
            S_KEYEXP: if (cnt_reg == CNT_SIZE'(NUM_RND)) state_next = S_INIT;
            S_INIT:   state_next = S_ROUND;
            S_ROUND:  if (cnt_reg == CNT_SIZE'(1)) state_next = S_FINAL;
            S_FINAL:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            pt_reg    <= '0;
            valid_reg <= 1'b0;
            kv_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= (state_reg == S_FINAL);
            case (state_reg)
                S_IDLE:   if (expand) cnt_reg <= CNT_SIZE'(1);
                S_KEYEXP: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_SIZE'(NUM_RND)) kv_reg <= 1'b1;
                end
                S_INIT:   cnt_reg <= CNT_SIZE'(NUM_RND - 1);
                S_ROUND:  cnt_reg <= cnt_reg - 1'b1;
                S_FINAL:  pt_reg  <= add_key;
                default:  cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Data registers without reset; the FSM decides when they matter
    always_ff @(posedge clk) begin
        if (!rst_n && rk_we) rk_mem[rk_waddr] <= rk_wdata;
        st_reg <= st_next;
        if (accept) ct_reg <= i_cypher_text;
    end

    assign o_plain_text = pt_reg;
    assign o_valid      = valid_reg;
    assign o_busy       = (state_reg != S_IDLE);
    assign o_key_valid  = kv_reg;

endmodule

// File: tb/tb_aes_inv_data_path.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_data_path
//   Directed bench for the iterative AES-128 inverse cipher. A transaction
//   model (latency bookkeeping plus a table-driven software decrypt) predicts
//   every output on every cycle; FIPS-197 vectors pin the model itself.
// -----------------------------------------------------------------------------
module tb_aes_inv_data_path;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] JUNK   = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    logic         clk = 1'b0;
    logic         rst_n, i_start, i_new_key;
    logic [127:0] i_cypher_text, i_key, o_plain_text;
    logic         o_valid, o_busy, o_key_valid;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    aes_inv_data_path dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_new_key     (i_new_key),
        .i_cypher_text (i_cypher_text),
        .i_key         (i_key),
        .o_plain_text  (o_plain_text),
        .o_valid       (o_valid),
        .o_busy        (o_busy),
        .o_key_valid   (o_key_valid)
    );

    // ---------------- software AES ----------------
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input int k);
        logic [7:0] x2, x4, x8;
        x2 = xt(a); x4 = xt(x2); x8 = xt(x4);
        case (k)
            9:       return x8 ^ a;
            11:      return x8 ^ x2 ^ a;
            13:      return x8 ^ x4 ^ a;
            14:      return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] m_next_rk(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sb[k[23:16]], sb[k[15:8]], sb[k[7:0]], sb[k[31:24]]} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] m_rk(input logic [127:0] key, input int n);
        logic [127:0] k;
        logic [7:0]   rc;
        k = key; rc = 8'h01;
        for (int i = 0; i < n; i++) begin
            k = m_next_rk(k, rc);
            rc = xt(rc);
        end
        return k;
    endfunction

    function automatic logic [127:0] m_decrypt(input logic [127:0] ct, input logic [127:0] key);
        logic [127:0] rk [11];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 11; i++) rk[i] = m_rk(key, i);
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk[10][127-8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[4*c+w] = isb[s[4*((c-w+4)%4)+w]] ^ rk[r][127-8*(4*c+w) -: 8];
            for (int c = 0; c < 4; c++) begin
                if (r > 0) begin
                    s[4*c]   = gm(t[4*c],14) ^ gm(t[4*c+1],11) ^ gm(t[4*c+2],13) ^ gm(t[4*c+3],9);
                    s[4*c+1] = gm(t[4*c],9)  ^ gm(t[4*c+1],14) ^ gm(t[4*c+2],11) ^ gm(t[4*c+3],13);
                    s[4*c+2] = gm(t[4*c],13) ^ gm(t[4*c+1],9)  ^ gm(t[4*c+2],14) ^ gm(t[4*c+3],11);
                    s[4*c+3] = gm(t[4*c],11) ^ gm(t[4*c+1],13) ^ gm(t[4*c+2],9)  ^ gm(t[4*c+3],14);
                end else begin
                    for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- transaction model ----------------
    // Accept at edge e: expansion finishes at e+10, result appears after
    // edge e+21 (new key) or e+11 (cached key).
    int           edge_n = 0;
    int           m_done_edge = -1;
    int           m_kv_edge = -1;
    logic         m_busy = 1'b0, m_valid = 1'b0, m_kv = 1'b0;
    logic         pre_busy, pre_kv, m_expand;
    logic [127:0] m_pt = '0, m_pending = '0, m_key = '0;

    initial forever begin
        @(posedge clk);
        edge_n++;
        pre_busy = m_busy;
        pre_kv   = m_kv;
        if (rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_kv = 1'b0; m_pt = '0;
            m_done_edge = -1; m_kv_edge = -1;
        end else begin
            m_valid = 1'b0;
            if (m_done_edge == edge_n) begin
                m_valid = 1'b1; m_pt = m_pending; m_busy = 1'b0;
            end
            if (m_kv_edge == edge_n) m_kv = 1'b1;
            if (!pre_busy && i_start) begin
                m_expand = i_new_key || !pre_kv;
                if (m_expand) begin
                    m_key = i_key;
                    m_kv_edge = edge_n + 10;
                end
                m_pending   = m_decrypt(i_cypher_text, m_key);
                m_done_edge = edge_n + (m_expand ? 21 : 11);
                m_busy      = 1'b1;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checks++;
            if ({o_valid, o_busy, o_key_valid, o_plain_text} !== {m_valid, m_busy, m_kv, m_pt}) begin
                errors++;
                $display("FAIL cycle_model t=%0t: dut v=%b busy=%b kv=%b pt=%h ; expected v=%b busy=%b kv=%b pt=%h",
                         $time, o_valid, o_busy, o_key_valid, o_plain_text, m_valid, m_busy, m_kv, m_pt);
            end
        end
    end

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one block and wait (bounded) for its o_valid pulse
    task automatic run_block(input string name, input logic nk, input logic [127:0] key,
                             input logic [127:0] ct, input logic [127:0] exp_pt, input int exp_lat);
        int n;
        i_start = 1'b1; i_new_key = nk; i_key = key; i_cypher_text = ct;
        @(negedge clk);
        i_start = 1'b0; i_key = JUNK; i_cypher_text = ~ct;
        n = 1;
        while (!o_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val({name, "_latency"}, 128'(o_valid ? n : 0), 128'(exp_lat));
        check_val({name, "_pt"}, o_plain_text, exp_pt);
        $display("block %s new_key=%0d latency=%0d pt=%h", name, nk, n, o_plain_text);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses, lat;
        logic [7:0] p, q;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

        // Pin the software model with the published vectors
        check_val("model_c1", m_decrypt(C1_CT, C1_KEY), C1_PT);
        check_val("model_appb", m_decrypt(B_CT, B_KEY), B_PT);
        check_val("model_appb_rk10", m_rk(B_KEY, 10), B_RK10);

        rst_n = 1'b1; i_start = 1'b0; i_new_key = 1'b0; i_key = '0; i_cypher_text = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        chk_en = 1'b1;
        check_val("reset_pt", o_plain_text, '0);
        check_val("reset_flags", {125'h0, o_valid, o_busy, o_key_valid}, '0);

        // FIPS-197 C.1 with expansion, then reuse with garbage key
        run_block("c1_new", 1'b1, C1_KEY, C1_CT, C1_PT, 22);
        run_block("c1_reuse", 1'b0, JUNK, C1_CT, C1_PT, 12);

        // Start in the o_valid cycle and keep i_start high while busy
        i_start = 1'b1; i_new_key = 1'b0; i_key = JUNK; i_cypher_text = C1_CT;
        pulses = 0; lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (o_valid) begin
                pulses++;
                if (lat == 0) lat = n;
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        check_val("b2b_pulses", 128'(pulses), 128'(1));
        check_val("b2b_latency", 128'(lat), 128'(12));
        check_val("b2b_pt", o_plain_text, C1_PT);
        $display("block b2b pulses=%0d latency=%0d pt=%h", pulses, lat, o_plain_text);

        // Key switch: App.B then C.1, both expanding
        run_block("appb_new", 1'b1, B_KEY, B_CT, B_PT, 22);
        check_val("appb_kv", {127'h0, o_key_valid}, 128'h1);
        run_block("c1_switch", 1'b1, C1_KEY, C1_CT, C1_PT, 22);

        // Reset during expansion at cnt=5
        i_start = 1'b1; i_new_key = 1'b1; i_key = C1_KEY; i_cypher_text = C1_CT;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check_val("midrst_pt", o_plain_text, '0);
        check_val("midrst_flags", {125'h0, o_valid, o_busy, o_key_valid}, '0);
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (o_valid) pulses++;
        end
        check_val("midrst_no_valid", 128'(pulses), 128'(0));
        $display("block midrst pulses=%0d kv=%b pt=%h", pulses, o_key_valid, o_plain_text);

        // Reuse request with no cached key is forced to expand
        run_block("appb_forced", 1'b0, B_KEY, B_CT, B_PT, 22);
        run_block("appb_reuse", 1'b0, JUNK, B_CT, B_PT, 12);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
